// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, 33-cycle radix-2 restoring divider, data RAM request port.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes in one cycle.
`ifndef ID_TO_EXE_WD
`define ID_TO_EXE_WD 154
`endif
`ifndef EXE_TO_MEM_WD
`define EXE_TO_MEM_WD 74
`endif
`ifndef EXE_TO_ID_WD
`define EXE_TO_ID_WD 40
`endif

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);
    // One-hot ops: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui
    always_comb begin
        result = 32'd0;
        unique case (1'b1)
            alu_op[0]:  result = src1 + src2;
            alu_op[1]:  result = src1 - src2;
            alu_op[2]:  result = {31'd0, $signed(src1) < $signed(src2)};
            alu_op[3]:  result = {31'd0, src1 < src2};
            alu_op[4]:  result = src1 & src2;
            alu_op[5]:  result = ~(src1 | src2);
            alu_op[6]:  result = src1 | src2;
            alu_op[7]:  result = src1 ^ src2;
            alu_op[8]:  result = src1 << src2[4:0];
            alu_op[9]:  result = src1 >> src2[4:0];
            alu_op[10]: result = $signed(src1) >>> src2[4:0];
            alu_op[11]: result = src2;
            default:    result = 32'd0;
        endcase
    end
endmodule

module exe_stage (
    input  logic                      clk,
    input  logic                      resetn,
    output logic                      exe_allowin,
    input  logic                      id_to_exe_valid,
    input  logic [`ID_TO_EXE_WD-1:0]  id_to_exe_bus,
    input  logic                      mem_allowin,
    output logic                      exe_to_mem_valid,
    output logic [`EXE_TO_MEM_WD-1:0] exe_to_mem_bus,
    output logic [`EXE_TO_ID_WD-1:0]  exe_to_id_bus,
    output logic                      data_sram_en,
    output logic [3:0]                data_sram_we,
    output logic [31:0]               data_sram_addr,
    output logic [31:0]               data_sram_wdata
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    logic                     exe_valid_reg;
    logic [`ID_TO_EXE_WD-1:0] bus_reg;
    div_state_t               div_state_reg, div_state_next;
    logic [4:0]               div_cnt_reg;
    logic [31:0]              quo_reg, rem_reg, dvs_reg;

    logic [11:0] alu_op;
    logic [31:0] src1, src2, store_data, pc;
    logic [2:0]  div_op;
    logic        reg_w, res_from_mem, load_sign, mem_we;
    logic [4:0]  reg_w_addr;
    logic [1:0]  mem_ins;

    assign {alu_op, src1, src2, div_op, reg_w, reg_w_addr, res_from_mem,
            mem_ins, load_sign, mem_we, store_data, pc} = bus_reg;

    logic [31:0] alu_result, exe_result, div_result;
    logic        exe_ready_go, div_start;

    alu u_alu (.alu_op(alu_op), .src1(src1), .src2(src2), .result(alu_result));

    assign exe_ready_go     = ~div_op[2] | (div_state_reg == DONE);
    assign exe_allowin      = ~exe_valid_reg | (exe_ready_go & mem_allowin);
    assign exe_to_mem_valid = exe_valid_reg & exe_ready_go;
    assign div_start        = exe_valid_reg & div_op[2] & (div_state_reg == IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exe_valid_reg <= 1'b0;
            bus_reg       <= '0;
        end else if (exe_allowin) begin
            exe_valid_reg <= id_to_exe_valid;
            if (id_to_exe_valid) bus_reg <= id_to_exe_bus;
        end
    end

    // Signed ops divide magnitudes and fix the signs afterwards from the held operands.
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b, quo_final, rem_final;
    assign a_neg     = ~div_op[1] & src1[31];
    assign b_neg     = ~div_op[1] & src2[31];
    assign mag_a     = a_neg ? -src1 : src1;
    assign mag_b     = b_neg ? -src2 : src2;
    assign quo_final = (a_neg ^ b_neg) ? -quo_reg : quo_reg;
    assign rem_final = a_neg ? -rem_reg : rem_reg;

    always_comb begin
        div_result = div_op[0] ? rem_final : quo_final;
`ifdef DIV_ZERO_FAST_EN
        if (src2 == 32'd0) div_result = div_op[0] ? src1 : 32'hFFFF_FFFF;
`endif
    end

    always_comb begin
        div_state_next = div_state_reg;
        case (div_state_reg)
            IDLE: if (div_start) begin
`ifdef DIV_ZERO_FAST_EN
                div_state_next = (src2 == 32'd0) ? DONE : CALC;
`else
                div_state_next = CALC;
`endif
            end
            CALC: if (div_cnt_reg == 5'd31) div_state_next = DONE;
            DONE: if (mem_allowin) div_state_next = IDLE;
            default: div_state_next = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    logic [32:0] partial;
    logic [31:0] sub_val;
    logic        fits;
    assign partial = {rem_reg, quo_reg[31]};
    assign fits    = partial >= {1'b0, dvs_reg};
    assign sub_val = partial[31:0] - dvs_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_state_reg <= IDLE;
            div_cnt_reg   <= 5'd0;
            quo_reg       <= 32'd0;
            rem_reg       <= 32'd0;
            dvs_reg       <= 32'd0;
        end else begin
            div_state_reg <= div_state_next;
            if (div_start) begin
                quo_reg     <= mag_a;
                rem_reg     <= 32'd0;
                dvs_reg     <= mag_b;
                div_cnt_reg <= 5'd0;
            end else if (div_state_reg == CALC) begin
                quo_reg     <= {quo_reg[30:0], fits};
                rem_reg     <= fits ? sub_val : partial[31:0];
                div_cnt_reg <= div_cnt_reg + 5'd1;
            end
        end
    end

    assign exe_result     = div_op[2] ? div_result : alu_result;
    assign exe_to_mem_bus = {reg_w, reg_w_addr, res_from_mem, exe_result, mem_ins, load_sign, pc};
    assign exe_to_id_bus  = {exe_valid_reg, reg_w, reg_w_addr, res_from_mem, exe_result};

    logic [3:0] we_mask;
    always_comb begin
        we_mask         = 4'b0000;
        data_sram_wdata = store_data;
        case (mem_ins)
            2'b01: begin
                we_mask         = 4'b0001 << alu_result[1:0];
                data_sram_wdata = {4{store_data[7:0]}};
            end
            2'b10: begin
                we_mask         = alu_result[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{store_data[15:0]}};
            end
            2'b11: we_mask = 4'b1111;
            default: we_mask = 4'b0000;
        endcase
    end

    // The write strobe waits for mem_allowin so a stalled store is written only once.
    assign data_sram_en   = exe_valid_reg & (res_from_mem | mem_we);
    assign data_sram_we   = (exe_valid_reg & mem_we & mem_allowin) ? we_mask : 4'b0000;
    assign data_sram_addr = alu_result;
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have no parameters; bus widths come from mycpu.h macros ID_TO_EXE_WD=154, EXE_TO_MEM_WD=74, EXE_TO_ID_WD=40.
REQ-002 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 exe_allowin  output  1  stage can accept a new instruction this cycle.
REQ-005 id_to_exe_valid  input  1  ID offers a valid instruction.
REQ-006 id_to_exe_bus  input  154  {alu_op[11:0], src1[31:0], src2[31:0], div_op[2:0] (bit2 div, bit1 unsigned, bit0 mod), regW, regWAddr[4:0], res_from_mem, memINS[1:0], load_sign, mem_we, store_data[31:0], pc[31:0]}.
REQ-007 mem_allowin  input  1  MEM stage can accept.
REQ-008 exe_to_mem_valid  output  1  EXE holds a finished valid instruction.
REQ-009 exe_to_mem_bus  output  74  {regW, regWAddr[4:0], res_from_mem, exe_result[31:0], memINS[1:0], load_sign, pc[31:0]}.
REQ-010 exe_to_id_bus  output  40  {exe_valid, regW, regWAddr[4:0], res_from_mem, exe_result[31:0]} for RAW forwarding and load-use stall.
REQ-011 data_sram_en  output  1;  data_sram_we  output  4;  data_sram_addr  output  32;  data_sram_wdata  output  32: synchronous data RAM request port.

Function
REQ-012 SHALL capture id_to_exe_bus into its stage register on a rising edge where exe_allowin & id_to_exe_valid; exe_valid SHALL load id_to_exe_valid whenever exe_allowin.
REQ-013 SHALL compute exe_ready_go = ~(div_op[2]) | (div_state==DONE); exe_allowin = ~exe_valid | exe_ready_go & mem_allowin; exe_to_mem_valid = exe_valid & exe_ready_go.
REQ-014 SHALL instantiate the existing alu on src1/src2/alu_op; exe_result = divider result when div_op[2], else ALU result.
REQ-015 Divider FSM SHALL have states IDLE, CALC, DONE: IDLE->CALC when exe_valid & div_op[2]; CALC->DONE after 32 iterations (counter 0..31); DONE->IDLE when mem_allowin.
REQ-016 Divider SHALL be radix-2 restoring on 32-bit magnitudes; signed ops take absolute values, negate quotient when operand signs differ, give remainder the dividend's sign; unsigned ops use raw operands.
REQ-017 A divide entering EXE at cycle T SHALL present exe_to_mem_valid=1 in cycle T+33; results SHALL be held stable in DONE until mem_allowin.
REQ-018 -2^31 / -1 signed SHALL yield quotient 0x80000000, remainder 0.
REQ-019 data_sram_en SHALL be exe_valid & (res_from_mem | mem_we); data_sram_addr = ALU result.
REQ-020 data_sram_we SHALL be 0 unless exe_valid & mem_we & mem_allowin, so each store writes exactly once; mask: memINS 01 -> one-hot byte from addr[1:0]; 10 -> 0011 if addr[1]==0 else 1100; 11 -> 1111.
REQ-021 data_sram_wdata SHALL replicate store_data[7:0] x4 (byte), store_data[15:0] x2 (half), store_data (word).
REQ-022 When mem_allowin is low in DONE or with a non-divide instruction, the stage register and outputs SHALL hold unchanged.

Reset
REQ-023 While resetn=0 (asynchronously): exe_valid=0, div_state=IDLE, div counter=0, exe_to_mem_valid=0, data_sram_we=0, data_sram_en=0.
REQ-024 Reset asserted mid-divide SHALL abandon it; after release the stage SHALL be empty with exe_allowin=1.

Configuration
REQ-025 Macro DIV_ZERO_FAST_EN defined: divisor 0 SHALL take IDLE->DONE directly (result in T+1) with quotient 0xFFFFFFFF, remainder = dividend, for all signedness.
REQ-026 DIV_ZERO_FAST_EN undefined: divisor 0 SHALL take the full 32 iterations (T+33) returning the raw algorithm output; no hang permitted.

Verification
REQ-027 add.w src1=5, src2=7, mem_allowin=1 -> next cycle exe_to_mem_valid=1, exe_result=12, exe_allowin stays 1.
REQ-028 div.w src1=-7, src2=2 at T -> exe_allowin=0 T..T+32, valid at T+33 with 0xFFFFFFFD; mod.w same operands -> 0xFFFFFFFF.
REQ-029 st.b addr=0x1003, data=0xAB, mem_allowin toggled 0,0,1 -> data_sram_we=1000 only in the mem_allowin=1 cycle, wdata=0xABABABAB.
REQ-030 div.wu 0x10/0 -> with DIV_ZERO_FAST_EN: valid at T+1, quotient 0xFFFFFFFF; without: valid at T+33.
REQ-031 resetn pulsed low at T+10 of a divide -> exe_to_mem_valid=0, div_state=IDLE immediately; next add completes in one cycle.
